// File: rtl/cla_seq_adder.sv
// Iterative WIDTH-bit add/subtract engine: a single 4-bit carry-lookahead slice is
// time-shared across the operand nibbles, LSB first, one nibble per clock.
module cla_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, sum_q;
    logic [IdxW-1:0]  idx_q;
    logic             carry_q, amsb_q, bmsb_q;
    logic             busy_q, done_q, cout_q, ovf_q;

    logic [3:0]       g, p, slice_sum;
    logic [4:0]       c;
    logic [WIDTH-1:0] acc_d;
    logic             idx_last;

    // Carry-lookahead slice over the low nibble of the shifting operands.
    always_comb begin
        g    = opa_q[3:0] & opb_q[3:0];
        p    = opa_q[3:0] ^ opb_q[3:0];
        c[0] = carry_q;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
        slice_sum = p ^ c[3:0];
    end

    generate
        if (WIDTH == 4) begin : g_single
            assign acc_d = slice_sum;
        end else begin : g_multi
            assign acc_d = {slice_sum, acc_q[WIDTH-1:4]};
        end
    endgenerate

    assign idx_last = (idx_q == IdxW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            amsb_q  <= 1'b0;
            bmsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        opa_q   <= a_i;
                        opb_q   <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i | cin_i;
                        amsb_q  <= a_i[WIDTH-1];
                        bmsb_q  <= sub_i ? ~b_i[WIDTH-1] : b_i[WIDTH-1];
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    acc_q   <= acc_d;
                    opa_q   <= opa_q >> 4;
                    opb_q   <= opb_q >> 4;
                    carry_q <= c[4];
                    idx_q   <= idx_q + IdxW'(1);
                    if (idx_last) begin
                        sum_q   <= acc_d;
                        cout_q  <= c[4];
                        // MSB carry-in xor carry-out, recovered from the MSB operand bits.
                        ovf_q   <= amsb_q ^ bmsb_q ^ acc_d[WIDTH-1] ^ c[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder at WIDTH=16.
module tb_cla_seq_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        cin_i = 1'b0;
    logic        sub_i = 1'b0;
    logic        busy_o, done_o, cout_o, ovf_o;
    logic [15:0] sum_o;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_seq_adder #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(start_i),
        .a_i    (a_i),
        .b_i    (b_i),
        .cin_i  (cin_i),
        .sub_i  (sub_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .sum_o  (sum_o),
        .cout_o (cout_o),
        .ovf_o  (ovf_o)
    );

    // Issues one op from an idle point (called #1 after a rising edge) and waits for done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, output int edges, output int busy_cnt);
        a_i = a; b_i = b; cin_i = cin; sub_i = sub; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        busy_cnt = busy_o ? 1 : 0;
        edges = 0;
        while (!done_o && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (busy_o) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done_o); end
        n_checks++; if (sum_o !== 16'h0) begin n_fail++; $display("FAIL reset_sum got %h want 0000", sum_o); end
        n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL reset_cout got %0b want 0", cout_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", ovf_o); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_basic();
        int edges, bc;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, edges, bc);
        n_checks++; if (edges !== 4) begin n_fail++; $display("FAIL basic_latency got %0d want 4", edges); end
        n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 4", bc); end
        n_checks++; if (sum_o !== 16'h5555) begin n_fail++; $display("FAIL basic_sum got %h want 5555", sum_o); end
        n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL basic_cout got %0b want 0", cout_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL basic_ovf got %0b want 0", ovf_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL basic_busy_in_done got %0b want 0", busy_o); end
        @(posedge clk); #1;
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL basic_done_width got %0b want 0", done_o); end
        n_checks++; if (sum_o !== 16'h5555) begin n_fail++; $display("FAIL basic_sum_hold got %h want 5555", sum_o); end
    endtask

    task automatic test_add_carry();
        int edges, bc;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, edges, bc);
        n_checks++; if (sum_o !== 16'h0000) begin n_fail++; $display("FAIL carry_sum got %h want 0000", sum_o); end
        n_checks++; if (cout_o !== 1'b1) begin n_fail++; $display("FAIL carry_cout got %0b want 1", cout_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL carry_ovf got %0b want 0", ovf_o); end
        @(posedge clk); #1;
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, edges, bc);
        n_checks++; if (sum_o !== 16'h8000) begin n_fail++; $display("FAIL povf_sum got %h want 8000", sum_o); end
        n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL povf_cout got %0b want 0", cout_o); end
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL povf_ovf got %0b want 1", ovf_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_cin();
        int edges, bc;
        run_op(16'h00FF, 16'h0000, 1'b1, 1'b0, edges, bc);
        n_checks++; if (sum_o !== 16'h0100) begin n_fail++; $display("FAIL cin_sum got %h want 0100", sum_o); end
        n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL cin_cout got %0b want 0", cout_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub();
        int edges, bc;
        // cin=1 here must be ignored in subtract mode.
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, edges, bc);
        n_checks++; if (sum_o !== 16'hFFFE) begin n_fail++; $display("FAIL sub1_sum got %h want fffe", sum_o); end
        n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL sub1_cout got %0b want 0", cout_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL sub1_ovf got %0b want 0", ovf_o); end
        @(posedge clk); #1;
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, edges, bc);
        n_checks++; if (sum_o !== 16'h7FFF) begin n_fail++; $display("FAIL sub2_sum got %h want 7fff", sum_o); end
        n_checks++; if (cout_o !== 1'b1) begin n_fail++; $display("FAIL sub2_cout got %0b want 1", cout_o); end
        n_checks++; if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL sub2_ovf got %0b want 1", ovf_o); end
        @(posedge clk); #1;
        run_op(16'hABCD, 16'hABCD, 1'b0, 1'b1, edges, bc);
        n_checks++; if (sum_o !== 16'h0000) begin n_fail++; $display("FAIL sub3_sum got %h want 0000", sum_o); end
        n_checks++; if (cout_o !== 1'b1) begin n_fail++; $display("FAIL sub3_cout got %0b want 1", cout_o); end
        n_checks++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL sub3_ovf got %0b want 0", ovf_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        // Op 1: 0x1111 + 0x2222 accepted from IDLE with start held high throughout.
        a_i = 16'h1111; b_i = 16'h2222; cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= 4; i++) begin
            a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom); sub_i = 1'($urandom);
            @(posedge clk); #1;
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 got %0b want 1", done_o); end
        n_checks++; if (sum_o !== 16'h3333) begin n_fail++; $display("FAIL b2b_sum1 got %h want 3333", sum_o); end
        // Op 2, accepted in the DONE cycle: 0x3000 - 0x0001.
        a_i = 16'h3000; b_i = 16'h0001; cin_i = 1'b0; sub_i = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept got %0b want 1", busy_o); end
        for (int i = 1; i <= 4; i++) begin
            a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom); sub_i = 1'($urandom);
            @(posedge clk); #1;
            if (i < 4) begin
                n_checks++;
                if (sum_o !== 16'h3333 || done_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_hold cyc %0d got sum %h done %0b want 3333 0", i, sum_o, done_o);
                end
            end
        end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %0b want 1", done_o); end
        n_checks++; if (sum_o !== 16'h2FFF) begin n_fail++; $display("FAIL b2b_sum2 got %h want 2fff", sum_o); end
        n_checks++; if (cout_o !== 1'b1) begin n_fail++; $display("FAIL b2b_cout2 got %0b want 1", cout_o); end
        start_i = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got busy %0b done %0b want 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_reset_mid_run();
        int edges, bc;
        bit saw_done;
        a_i = 16'h1234; b_i = 16'h1111; cin_i = 1'b0; sub_i = 1'b0; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy_o); end
        n_checks++; if (sum_o !== 16'h0) begin n_fail++; $display("FAIL abort_sum got %h want 0000", sum_o); end
        n_checks++; if (cout_o !== 1'b0) begin n_fail++; $display("FAIL abort_cout got %0b want 0", cout_o); end
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done_o) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got %0b want 0", saw_done); end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, edges, bc);
        n_checks++; if (edges !== 4) begin n_fail++; $display("FAIL post_reset_latency got %0d want 4", edges); end
        n_checks++; if (sum_o !== 16'h0002) begin n_fail++; $display("FAIL post_reset_sum got %h want 0002", sum_o); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_add_carry();
        test_cin();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
